// File: rtl/exe_lsu_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exe_lsu_if : instruction-side and memory-side signal bundle for exe_lsu
// Rev 1.0
// ----------------------------------------------------------------------------
interface exe_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      valid_i;
  logic                      ready_o;
  logic [31:0]               inst_i;
  logic [DATA_WIDTH-1:0]     op1_i;
  logic [DATA_WIDTH-1:0]     op2_i;
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH/8-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic                      mem_ack_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      done_o;
  logic                      reg_we_o;
  logic [DATA_WIDTH-1:0]     reg_wdata_o;
  logic                      err_o;
  logic [1:0]                err_code_o;

  modport slave (
    input  valid_i, inst_i, op1_i, op2_i, mem_ack_i, mem_rdata_i,
    output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           done_o, reg_we_o, reg_wdata_o, err_o, err_code_o
  );

  modport master (
    output valid_i, inst_i, op1_i, op2_i, mem_ack_i, mem_rdata_i,
    input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           done_o, reg_we_o, reg_wdata_o, err_o, err_code_o
  );
endinterface
`default_nettype wire

// File: rtl/exe_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exe_lsu : single-outstanding load/store unit with alignment, funct3 and
//           bus-timeout error reporting
// Rev 1.0
// ----------------------------------------------------------------------------
module exe_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  exe_lsu_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [1:0]              err_q, err_d;

  logic [6:0]              w_opcode;
  logic [2:0]              w_f3;
  logic                    w_is_load, w_is_store, w_legal, w_misalign;
  logic [11:0]             w_imm;
  logic [ADDR_WIDTH-1:0]   w_ea;
  logic [DATA_WIDTH/8-1:0] w_be;
  logic [DATA_WIDTH-1:0]   w_wdata, w_lane, w_load_ext;
  logic                    w_req, w_done;
  logic                    w_unused;

  assign w_opcode   = bus.inst_i[6:0];
  assign w_f3       = bus.inst_i[14:12];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_imm      = w_is_store ? {bus.inst_i[31:25], bus.inst_i[11:7]} : bus.inst_i[31:20];
  assign w_ea       = bus.op1_i[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-12){w_imm[11]}}, w_imm};
  assign w_unused   = ^bus.inst_i[19:15];

  always_comb begin
    w_legal = 1'b0;
    if (w_is_load)
      w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                (w_f3 == 3'b100) || (w_f3 == 3'b101);
    else if (w_is_store)
      w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
  end

  assign w_misalign = ((w_f3[1:0] == 2'b01) && w_ea[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));

  // funct3[1:0] encodes access size for both loads and stores.
  always_comb begin
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_ea[1:0];
        w_wdata = {4{bus.op2_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_ea[1:0];
        w_wdata = {2{bus.op2_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.op2_i;
      end
    endcase
  end

  assign w_lane = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_ext = {24'd0, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_ext = {16'd0, w_lane[15:0]};
      default: w_load_ext = bus.mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i && (w_is_load || w_is_store)) begin
          addr_d   = w_ea;
          wdata_d  = w_wdata;
          be_d     = w_be;
          we_d     = w_is_store;
          funct3_d = w_f3;
          cnt_d    = 8'd0;
          result_d = '0;
          if (!w_legal) begin
            err_d   = ERR_FUNCT3;
            state_d = S_DONE;
          end else if (w_misalign) begin
            err_d   = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_NONE;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack arriving on the final allowed cycle still wins over timeout.
        if (bus.mem_ack_i) begin
          result_d = w_load_ext;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      cnt_q    <= 8'd0;
      result_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign w_req  = (state_q == S_REQ);
  assign w_done = (state_q == S_DONE);

  assign bus.ready_o     = (state_q == S_IDLE);
  assign bus.mem_req_o   = w_req;
  assign bus.mem_we_o    = w_req & we_q;
  assign bus.mem_addr_o  = w_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_be_o    = w_req ? be_q : '0;
  assign bus.mem_wdata_o = w_req ? wdata_q : '0;
  assign bus.done_o      = w_done;
  assign bus.err_o       = w_done && (err_q != ERR_NONE);
  assign bus.err_code_o  = w_done ? err_q : ERR_NONE;
  assign bus.reg_we_o    = w_done && !we_q && (err_q == ERR_NONE);
  assign bus.reg_wdata_o = bus.reg_we_o ? result_q : '0;

endmodule
`default_nettype wire
